// File: rtl/pc_gen_unit.sv
// ============================================================================
// Module      : pc_gen_unit
// Description : Next-PC generator that owns the fetch PC. It selects between
//               sequential, branch, JALR and trap sources and holds redirects
//               while fetch is stalled. Optional feature macro: PC_RVC_EN
//               (16-bit instruction increment and 2-byte target alignment).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic [1:0]       pcsrc,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jalr_target,
  input  logic             trap,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             is_compressed,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic             misalign,
  output logic             redirect_pend
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  pend_target;

  logic             fire;
  logic [XLEN-1:0]  inc;
  logic             redirect_req;
  logic [XLEN-1:0]  target;
  logic             target_misaligned;
  logic             valid_redirect;
  logic             unused_bits;

  assign fire = pc_valid & imem_ready & ~stall;

`ifdef PC_RVC_EN
  assign inc               = is_compressed ? XLEN'(2) : XLEN'(4);
  assign target_misaligned = target[0];
`else
  assign inc               = XLEN'(4);
  assign target_misaligned = (target[1:0] != 2'b00);
`endif

  // jalr_target[0] is always cleared and is_compressed is ignored without RVC
  assign unused_bits = ^{is_compressed, jalr_target[0]};

  assign pc_plus_inc    = pc_o + inc;
  assign redirect_req   = (pcsrc == 2'b01) || (pcsrc == 2'b10);
  assign target         = (pcsrc == 2'b01) ? branch_target
                                           : {jalr_target[XLEN-1:1], 1'b0};
  assign valid_redirect = redirect_req & ~target_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc_o          <= RESET_VECTOR;
      pc_valid      <= 1'b0;
      misalign      <= 1'b0;
      redirect_pend <= 1'b0;
      pend_target   <= '0;
    end else begin
      // A misaligned redirect is only reported when it would otherwise have
      // been acted on: not during BOOT and not when a trap takes priority.
      misalign <= (state != BOOT) & ~trap & redirect_req & target_misaligned;

      case (state)
        BOOT: begin
          pc_valid <= 1'b1;
          state    <= RUN;
          if (trap) begin
            pc_o <= trap_vector;
          end
        end

        RUN: begin
          if (trap) begin
            pc_o <= trap_vector;
          end else if (fire && valid_redirect) begin
            pc_o <= target;
          end else if (fire) begin
            pc_o <= pc_plus_inc;
          end else if (valid_redirect) begin
            pend_target   <= target;
            redirect_pend <= 1'b1;
            state         <= HOLD;
          end
        end

        HOLD: begin
          if (trap) begin
            pc_o          <= trap_vector;
            redirect_pend <= 1'b0;
            state         <= RUN;
          end else if (fire) begin
            // A redirect arriving on the accepting cycle supersedes the latch
            pc_o          <= valid_redirect ? target : pend_target;
            redirect_pend <= 1'b0;
            state         <= RUN;
          end else if (valid_redirect) begin
            pend_target <= target;
          end
        end

        default: begin
          state         <= RUN;
          redirect_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
